// File: rtl/loader_write_arbiter.sv
// Per-stream write FIFO, then a round-robin arbiter onto one hold-until-ack memory write port.
// Latency: a strobe rising in cycle k raises mem_wr in cycle k+2; one word per (ack latency + 2) cycles.
// Backpressure: none toward loaders; a push into a full FIFO with no same-cycle pop is dropped and flagged sticky.
module loader_write_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_dat_o,
    output logic             empty_o,
    output logic             drop_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             push_ok;

    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push_ok    = push_i && ((count_q < CW'(DEPTH)) || pop_i);
    assign drop_o     = push_i && !push_ok;
    assign empty_o    = (count_q == '0);
    assign head_dat_o = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop_i) begin
            count_d = count_q + 1'b1;
        end else if (!push_ok && pop_i) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end
endmodule

module loader_write_arbiter #(
    parameter int ADDRESS_SIZE = 24,
    parameter int DATA_WIDTH   = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                    clk_memory,
    input  logic                    reset_n,
    input  logic                    a_write_en,
    input  logic [ADDRESS_SIZE:0]   a_write_addr,
    input  logic [DATA_WIDTH-1:0]   a_write_data,
    input  logic                    b_write_en,
    input  logic [ADDRESS_SIZE:0]   b_write_addr,
    input  logic [DATA_WIDTH-1:0]   b_write_data,
    output logic                    mem_wr,
    output logic [ADDRESS_SIZE:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_data,
    input  logic                    mem_ack,
    output logic                    busy,
    output logic                    a_overflow,
    output logic                    b_overflow
);
    localparam int AW = ADDRESS_SIZE + 1;

    typedef struct packed {
        logic [AW-1:0]         addr;
        logic [DATA_WIDTH-1:0] dat;
    } wr_word_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t                state_q;
    logic                  armed_q;
    logic                  a_en_prev_q;
    logic                  b_en_prev_q;
    logic                  last_grant_b_q;
    logic                  mem_wr_q;
    logic [AW-1:0]         mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_data_q;
    logic                  a_overflow_q;
    logic                  b_overflow_q;
    logic                  a_overflow_d;
    logic                  b_overflow_d;

    logic     a_push, b_push;
    logic     a_pop, b_pop;
    logic     a_empty, b_empty;
    logic     a_drop, b_drop;
    wr_word_t a_word, b_word;
    wr_word_t a_head, b_head;
    wr_word_t grant_word;

    // armed_q masks the first edge after reset so a strobe already high then is not a rising edge.
    assign a_push = armed_q && a_write_en && !a_en_prev_q;
    assign b_push = armed_q && b_write_en && !b_en_prev_q;
    assign a_word = {a_write_addr, a_write_data};
    assign b_word = {b_write_addr, b_write_data};

    loader_write_fifo #(
        .WIDTH ($bits(wr_word_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo_a (
        .clk_i      (clk_memory),
        .rst_ni     (reset_n),
        .push_i     (a_push),
        .push_dat_i (a_word),
        .pop_i      (a_pop),
        .head_dat_o (a_head),
        .empty_o    (a_empty),
        .drop_o     (a_drop)
    );

    loader_write_fifo #(
        .WIDTH ($bits(wr_word_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo_b (
        .clk_i      (clk_memory),
        .rst_ni     (reset_n),
        .push_i     (b_push),
        .push_dat_i (b_word),
        .pop_i      (b_pop),
        .head_dat_o (b_head),
        .empty_o    (b_empty),
        .drop_o     (b_drop)
    );

    // On a tie the stream not granted last wins; otherwise whichever has data.
    always_comb begin
        a_pop = 1'b0;
        b_pop = 1'b0;
        if (state_q == S_IDLE) begin
            if (!a_empty && !b_empty) begin
                a_pop = last_grant_b_q;
                b_pop = !last_grant_b_q;
            end else begin
                a_pop = !a_empty;
                b_pop = a_empty && !b_empty;
            end
        end
    end

    assign grant_word   = a_pop ? a_head : b_head;
    assign a_overflow_d = a_overflow_q | a_drop;
    assign b_overflow_d = b_overflow_q | b_drop;

    always_ff @(posedge clk_memory or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            armed_q        <= 1'b0;
            a_en_prev_q    <= 1'b0;
            b_en_prev_q    <= 1'b0;
            last_grant_b_q <= 1'b1;
            mem_wr_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_data_q     <= '0;
            a_overflow_q   <= 1'b0;
            b_overflow_q   <= 1'b0;
        end else begin
            armed_q      <= 1'b1;
            a_en_prev_q  <= a_write_en;
            b_en_prev_q  <= b_write_en;
            a_overflow_q <= a_overflow_d;
            b_overflow_q <= b_overflow_d;
            case (state_q)
                S_IDLE: begin
                    if (a_pop || b_pop) begin
                        mem_wr_q       <= 1'b1;
                        mem_addr_q     <= grant_word.addr;
                        mem_data_q     <= grant_word.dat;
                        last_grant_b_q <= b_pop;
                        state_q        <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (mem_ack) begin
                        mem_wr_q <= 1'b0;
                        state_q  <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign mem_wr     = mem_wr_q;
    assign mem_addr   = mem_addr_q;
    assign mem_data   = mem_data_q;
    assign a_overflow = a_overflow_q;
    assign b_overflow = b_overflow_q;
    assign busy       = !a_empty || !b_empty || (state_q == S_BUSY);
endmodule

// File: tb/tb_loader_write_arbiter.sv
// Bench for loader_write_arbiter: directed scenarios then random strobes/acks,
// every cycle compared against a queue-based reference of the arbiter.
`timescale 1ns/1ps
module tb_loader_write_arbiter;
    localparam int AS    = 24;
    localparam int AW    = AS + 1;
    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int WW    = AW + DW;

    logic          clk_memory = 1'b0;
    logic          reset_n    = 1'b1;
    logic          a_write_en = 1'b0;
    logic [AW-1:0] a_write_addr = '0;
    logic [DW-1:0] a_write_data = '0;
    logic          b_write_en = 1'b0;
    logic [AW-1:0] b_write_addr = '0;
    logic [DW-1:0] b_write_data = '0;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          mem_ack = 1'b0;
    logic          busy;
    logic          a_overflow;
    logic          b_overflow;

    loader_write_arbiter #(
        .ADDRESS_SIZE (AS),
        .DATA_WIDTH   (DW),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk_memory   (clk_memory),
        .reset_n      (reset_n),
        .a_write_en   (a_write_en),
        .a_write_addr (a_write_addr),
        .a_write_data (a_write_data),
        .b_write_en   (b_write_en),
        .b_write_addr (b_write_addr),
        .b_write_data (b_write_data),
        .mem_wr       (mem_wr),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .mem_ack      (mem_ack),
        .busy         (busy),
        .a_overflow   (a_overflow),
        .b_overflow   (b_overflow)
    );

    always #5 clk_memory = ~clk_memory;

    int checks = 0;
    int errors = 0;

    // Reference: per-stream word queues plus the single outstanding write.
    logic [WW-1:0] qa[$];
    logic [WW-1:0] qb[$];
    logic [WW-1:0] obs[$];
    bit            m_wr;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    bit            last_b = 1'b1;
    bit            ovf_a, ovf_b, prev_a, prev_b;
    int            m_issued = 0;
    bit            ack_en = 1'b0;
    int            ack_lat = 0;
    int            wait_cnt = 0;
    bit            dut_wr_prev = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obsv, input logic [63:0] expv);
        checks++;
        assert (obsv === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obsv, expv);
        end
    endtask

    function automatic logic [WW-1:0] obs_at(input int i);
        if (i < obs.size()) return obs[i];
        return '0;
    endfunction

    task automatic model_clear();
        qa.delete();
        qb.delete();
        m_wr     = 1'b0;
        m_addr   = '0;
        m_data   = '0;
        last_b   = 1'b1;
        ovf_a    = 1'b0;
        ovf_b    = 1'b0;
        m_issued = 0;
    endtask

    task automatic model_update();
        bit            take_a, take_b, rise_a, rise_b;
        logic [WW-1:0] w;
        take_a = 1'b0;
        take_b = 1'b0;
        w      = '0;
        if (!reset_n) begin
            model_clear();
            prev_a = a_write_en;
            prev_b = b_write_en;
            return;
        end
        rise_a = a_write_en && !prev_a;
        rise_b = b_write_en && !prev_b;
        if (m_wr) begin
            if (mem_ack) m_wr = 1'b0;
        end else if (qa.size() > 0 && qb.size() > 0) begin
            if (last_b) take_a = 1'b1;
            else        take_b = 1'b1;
        end else if (qa.size() > 0) begin
            take_a = 1'b1;
        end else if (qb.size() > 0) begin
            take_b = 1'b1;
        end
        if (take_a) begin w = qa.pop_front(); last_b = 1'b0; end
        if (take_b) begin w = qb.pop_front(); last_b = 1'b1; end
        if (take_a || take_b) begin
            m_wr = 1'b1;
            {m_addr, m_data} = w;
            m_issued++;
        end
        if (rise_a) begin
            if (qa.size() < DEPTH) qa.push_back({a_write_addr, a_write_data});
            else ovf_a = 1'b1;
        end
        if (rise_b) begin
            if (qb.size() < DEPTH) qb.push_back({b_write_addr, b_write_data});
            else ovf_b = 1'b1;
        end
        prev_a = a_write_en;
        prev_b = b_write_en;
    endtask

    task automatic step();
        @(posedge clk_memory);
        model_update();
        #1;
        chk("mem_wr", mem_wr, m_wr);
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_data", mem_data, m_data);
        chk("busy", busy, (qa.size() != 0) || (qb.size() != 0) || m_wr);
        chk("a_overflow", a_overflow, ovf_a);
        chk("b_overflow", b_overflow, ovf_b);
        if (mem_wr && !dut_wr_prev) obs.push_back({mem_addr, mem_data});
        dut_wr_prev = mem_wr;
        if (mem_ack) begin
            mem_ack = 1'b0;
        end else if (ack_en && m_wr) begin
            if (wait_cnt >= ack_lat) begin
                mem_ack  = 1'b1;
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        mem_ack  = 1'b0;
        wait_cnt = 0;
        #1;
        model_clear();
        prev_a = a_write_en;
        prev_b = b_write_en;
        obs.delete();
        dut_wr_prev = 1'b0;
        chk("rst_mem_wr", mem_wr, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_data", mem_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_a_ovf", a_overflow, 0);
        chk("rst_b_ovf", b_overflow, 0);
        step();
        step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic pulse(input bit sa, input bit sb, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                         input logic [AW-1:0] ba, input logic [DW-1:0] bd, input int hold);
        a_write_en = sa; a_write_addr = aa; a_write_data = ad;
        b_write_en = sb; b_write_addr = ba; b_write_data = bd;
        repeat (hold) step();
        a_write_en = 1'b0;
        b_write_en = 1'b0;
        step();
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < budget) begin
            step();
            n++;
        end
        chk("idle_timeout", busy, 0);
    endtask

    initial begin
        #2;
        do_reset();

        // Single write with a strobe held three cycles.
        ack_en = 1'b1; ack_lat = 2;
        a_write_en = 1'b1; a_write_addr = 25'h000010; a_write_data = 16'hBEEF;
        step();
        chk("single_wr_k1", mem_wr, 0);
        step();
        chk("single_wr_k2", mem_wr, 1);
        step();
        a_write_en = 1'b0;
        wait_idle(50);
        chk("single_count", obs.size(), 1);
        chk("single_word", obs_at(0), {25'h000010, 16'hBEEF});

        // Round robin: simultaneous A/B strobes, fixed ack latency.
        do_reset();
        ack_en = 1'b1; ack_lat = 2;
        for (int i = 0; i < 3; i++)
            pulse(1, 1, AW'(32'h100 + i), DW'(32'hA000 + i), AW'(32'h200 + i), DW'(32'hB000 + i), 1);
        wait_idle(200);
        chk("rr_count", obs.size(), 6);
        for (int i = 0; i < 3; i++) begin
            chk("rr_a", obs_at(2 * i), {AW'(32'h100 + i), DW'(32'hA000 + i)});
            chk("rr_b", obs_at(2 * i + 1), {AW'(32'h200 + i), DW'(32'hB000 + i)});
        end

        // Overflow: B word stalls the port, five A edges overflow a depth-4 FIFO.
        do_reset();
        ack_en = 1'b0;
        pulse(0, 1, '0, '0, 25'h300, 16'hC000, 1);
        for (int i = 0; i < 4; i++)
            pulse(1, 0, AW'(32'h400 + i), DW'(32'hD000 + i), '0, '0, 2);
        chk("ovf_after4", a_overflow, 0);
        pulse(1, 0, 25'h404, 16'hD004, '0, '0, 1);
        chk("ovf_after5", a_overflow, 1);
        chk("ovf_b_clear", b_overflow, 0);
        ack_en = 1'b1; ack_lat = 1;
        wait_idle(200);
        chk("ovf_count", obs.size(), 5);
        chk("ovf_first_b", obs_at(0), {25'h300, 16'hC000});
        for (int i = 0; i < 4; i++)
            chk("ovf_drain_a", obs_at(i + 1), {AW'(32'h400 + i), DW'(32'hD000 + i)});

        // Full FIFO accepts a push in the same cycle as a pop.
        do_reset();
        ack_en = 1'b0;
        for (int i = 0; i < 5; i++)
            pulse(1, 0, AW'(32'h500 + i), DW'(32'hE000 + i), '0, '0, 1);
        chk("fpp_no_ovf_pre", a_overflow, 0);
        mem_ack = 1'b1;
        step();
        a_write_en = 1'b1; a_write_addr = 25'h505; a_write_data = 16'hE005;
        step();
        a_write_en = 1'b0;
        chk("fpp_no_ovf", a_overflow, 0);
        step();
        pulse(1, 0, 25'h506, 16'hE006, '0, '0, 1);
        chk("fpp_still_full", a_overflow, 1);
        ack_en = 1'b1; ack_lat = 0;
        wait_idle(200);
        chk("fpp_count", obs.size(), 6);
        chk("fpp_last", obs_at(5), {25'h505, 16'hE005});

        // Reset mid-handshake, strobe held across release.
        do_reset();
        ack_en = 1'b0;
        for (int i = 0; i < 3; i++)
            pulse(1, 0, AW'(32'h600 + i), DW'(32'hF000 + i), '0, '0, 1);
        chk("mhr_busy_pre", mem_wr, 1);
        a_write_en = 1'b1;
        do_reset();
        ack_en = 1'b1; ack_lat = 0;
        repeat (3) step();
        a_write_en = 1'b0;
        repeat (15) step();
        chk("mhr_no_write", obs.size(), 0);

        // Stray ack in IDLE, then a normal write.
        mem_ack = 1'b1;
        step();
        chk("stray_wr", mem_wr, 0);
        chk("stray_busy", busy, 0);
        pulse(1, 0, 25'h0ABCDE, 16'h1234, '0, '0, 1);
        wait_idle(50);
        chk("stray_count", obs.size(), 1);
        chk("stray_word", obs_at(0), {25'h0ABCDE, 16'h1234});

        // Random strobes and ack latencies.
        do_reset();
        for (int c = 0; c < 800; c++) begin
            if (a_write_en) a_write_en = ($urandom_range(0, 1) == 0);
            else if ($urandom_range(0, 3) == 0) begin
                a_write_en = 1'b1; a_write_addr = AW'($urandom); a_write_data = DW'($urandom);
            end
            if (b_write_en) b_write_en = ($urandom_range(0, 1) == 0);
            else if ($urandom_range(0, 3) == 0) begin
                b_write_en = 1'b1; b_write_addr = AW'($urandom); b_write_data = DW'($urandom);
            end
            ack_en  = ($urandom_range(0, 9) != 0);
            ack_lat = $urandom_range(0, 3);
            step();
        end
        a_write_en = 1'b0;
        b_write_en = 1'b0;
        ack_en = 1'b1; ack_lat = 1;
        wait_idle(500);
        chk("rand_issued", obs.size(), m_issued);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end
endmodule
